des_perm_pipe: RTL and testbench

Multi-lane, mode-selectable DES bit-permutation engine with valid/ready handshake and a 2-entry output buffer. Each transaction carries NUM_CH independent 32-bit half-blocks. The mode is sampled per transaction: E-expansion, E-expansion XOR subkey, P-permutation, or bypass. It sits between the round-key scheduler and the S-box stage of the Feistel datapath and replaces the purely combinational expansion used so far.

---
 rtl/des_pkg.sv | 53 +++++
 rtl/des_perm_lane.sv | 28 ++
 rtl/des_perm_pipe.sv | 96 +++++++++
 tb/tb_des_perm_pipe.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// Shared definitions for the DES permutation engine: widths, mode encoding,
// the FIPS E and P tables, and helpers that apply them to one half-block.
package des_pkg;

    localparam int HALF_W = 32;
    localparam int EXP_W  = 48;

    typedef enum logic [1:0] {
        MODE_E       = 2'b00,
        MODE_E_XOR_K = 2'b01,
        MODE_P       = 2'b10,
        MODE_BYPASS  = 2'b11
    } mode_e;

    // Entry k holds the 1-based FIPS source bit for FIPS output bit k+1.
    localparam int E_TABLE [EXP_W] = '{
        32,  1,  2,  3,  4,  5,
         4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13,
        12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21,
        20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29,
        28, 29, 30, 31, 32,  1
    };

    localparam int P_TABLE [HALF_W] = '{
        16,  7, 20, 21, 29, 12, 28, 17,
         1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9,
        19, 13, 30,  6, 22, 11,  4, 25
    };

    // FIPS bit k (1 = MSB) lives at vector index WIDTH-k on both sides.
    function automatic logic [EXP_W-1:0] e_expand(input logic [HALF_W-1:0] d);
        logic [EXP_W-1:0] r;
        r = '0;
        for (int k = 0; k < EXP_W; k++) begin
            r[EXP_W-1-k] = d[HALF_W-E_TABLE[k]];
        end
        return r;
    endfunction

    function automatic logic [HALF_W-1:0] p_permute(input logic [HALF_W-1:0] d);
        logic [HALF_W-1:0] r;
        r = '0;
        for (int k = 0; k < HALF_W; k++) begin
            r[HALF_W-1-k] = d[HALF_W-P_TABLE[k]];
        end
        return r;
    endfunction

endpackage

// File: rtl/des_perm_lane.sv
// Single-lane combinational transform: 32-bit half-block (plus 48-bit subkey)
// to a 48-bit result according to the selected permutation mode.
module des_perm_lane
    import des_pkg::*;
(
    input  mode_e              mode,
    input  logic [HALF_W-1:0]  data,
    input  logic [EXP_W-1:0]   key,
    output logic [EXP_W-1:0]   result
);

    logic [EXP_W-1:0] expanded;

    // NOTE: every output of a combinational block gets a default on entry so
    // no path through the case can leave it unassigned and infer a latch.
    always_comb begin
        expanded = e_expand(data);
        result   = '0;
        case (mode)
            MODE_E:       result = expanded;
            MODE_E_XOR_K: result = expanded ^ key;
            MODE_P:       result = {{(EXP_W-HALF_W){1'b0}}, p_permute(data)};
            MODE_BYPASS:  result = {{(EXP_W-HALF_W){1'b0}}, data};
            default:      result = '0;
        endcase
    end

endmodule

// File: rtl/des_perm_pipe.sv
// Multi-lane DES permutation stage: per-lane transforms feed a 2-entry
// in-order output buffer with valid/ready on both sides and a transfer count.
module des_perm_pipe
    import des_pkg::*;
#(
    parameter int NUM_CH = 1,
    parameter int TAG_W  = 4
)
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               in_mode,
    input  logic [NUM_CH*HALF_W-1:0] in_data,
    input  logic [NUM_CH*EXP_W-1:0]  in_key,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NUM_CH*EXP_W-1:0]  out_data,
    output logic [TAG_W-1:0]         out_tag,
    output logic [15:0]              xfer_cnt
);

    localparam int OUT_W = NUM_CH*EXP_W;

    typedef struct packed {
        logic [OUT_W-1:0] data;
        logic [TAG_W-1:0] tag;
    } entry_t;

    entry_t           mem [2];
    logic             rd_ptr;
    logic             wr_ptr;
    logic             show_ptr;
    logic [1:0]       count;
    logic [OUT_W-1:0] lane_result;
    logic             push;
    logic             pop;
    mode_e            mode;

    assign mode = mode_e'(in_mode);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
        des_perm_lane u_lane (
            .mode   (mode),
            .data   (in_data[i*HALF_W +: HALF_W]),
            .key    (in_key[i*EXP_W +: EXP_W]),
            .result (lane_result[i*EXP_W +: EXP_W])
        );
    end

    // Ready comes from the registered fill level only, so a full buffer
    // refuses input even when downstream drains in the same cycle.
    assign in_ready  = !rst && (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // When empty, point at the slot just popped so the outputs keep the last
    // presented value instead of exposing a stale older entry.
    assign show_ptr = out_valid ? rd_ptr : ~rd_ptr;
    assign out_data = mem[show_ptr].data;
    assign out_tag  = mem[show_ptr].tag;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            count    <= 2'd0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            xfer_cnt <= 16'd0;
            // NOTE: the buffer is cleared on reset because the idle outputs
            // are read straight from it and must be zero, not X.
            for (int i = 0; i < 2; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= '{data: lane_result, tag: in_tag};
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr   <= ~rd_ptr;
                xfer_cnt <= xfer_cnt + 16'd1;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_des_perm_pipe.sv
// Scoreboard bench for des_perm_pipe (4 lanes): a negedge monitor models the
// buffer with a queue of expected results from an arithmetic DES model.
module tb_des_perm_pipe;

    localparam int NUM_CH = 4;
    localparam int TAG_W  = 4;
    localparam int IW     = NUM_CH*32;
    localparam int KW     = NUM_CH*48;
    localparam int OW     = NUM_CH*48;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [1:0]        in_mode = 2'b00;
    logic [IW-1:0]     in_data = '0;
    logic [KW-1:0]     in_key = '0;
    logic [TAG_W-1:0]  in_tag = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [OW-1:0]     out_data;
    logic [TAG_W-1:0]  out_tag;
    logic [15:0]       xfer_cnt;

    des_perm_pipe #(.NUM_CH(NUM_CH), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_data   (in_data),
        .in_key    (in_key),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .xfer_cnt  (xfer_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int stall_cycles = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int p_fips [32] = '{16, 7, 20, 21, 29, 12, 28, 17,
                        1, 15, 23, 26, 5, 18, 31, 10,
                        2, 8, 24, 14, 32, 27, 3, 9,
                        19, 13, 30, 6, 22, 11, 4, 25};

    // E is 8 rows of 6: each row re-reads the neighbours of a 4-bit group.
    function automatic logic [47:0] model_lane(input logic [1:0] m, input logic [31:0] d,
                                               input logic [47:0] k);
        logic [47:0] e;
        logic [31:0] p;
        int src;
        for (int j = 0; j < 48; j++) begin
            src = ((j / 6) * 4 + (j % 6) + 31) % 32 + 1;
            e[47-j] = d[32-src];
        end
        for (int j = 0; j < 32; j++) p[31-j] = d[32-p_fips[j]];
        case (m)
            2'b00:   return e;
            2'b01:   return e ^ k;
            2'b10:   return {16'h0, p};
            default: return {16'h0, d};
        endcase
    endfunction

    function automatic logic [OW-1:0] model(input logic [1:0] m, input logic [IW-1:0] d,
                                            input logic [KW-1:0] k);
        logic [OW-1:0] r;
        for (int i = 0; i < NUM_CH; i++) r[i*48 +: 48] = model_lane(m, d[i*32 +: 32], k[i*48 +: 48]);
        return r;
    endfunction

    typedef struct {
        logic [OW-1:0]    data;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t             exp_q [$];
    logic [15:0]      model_xfer = '0;
    logic [OW-1:0]    last_data = '0;
    logic [TAG_W-1:0] last_tag = '0;

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        bit do_pop;
        bit do_push;
        exp_t e;
        if (rst) begin
            check("in_ready_during_reset", {255'h0, in_ready}, 256'h0);
            exp_q.delete();
            model_xfer = '0;
            last_data  = '0;
            last_tag   = '0;
        end else begin
            check("out_valid", {255'h0, out_valid}, {255'h0, exp_q.size() != 0});
            check("in_ready", {255'h0, in_ready}, {255'h0, exp_q.size() != 2});
            check("xfer_cnt", {240'h0, xfer_cnt}, {240'h0, model_xfer});
            if (exp_q.size() != 0) begin
                check("out_data", out_data, exp_q[0].data);
                check("out_tag", out_tag, exp_q[0].tag);
            end else begin
                check("idle_hold_data", out_data, last_data);
                check("idle_hold_tag", out_tag, last_tag);
            end
            do_pop  = (exp_q.size() != 0) && out_ready;
            do_push = in_valid && (exp_q.size() != 2);
            if (do_pop) begin
                last_data = exp_q[0].data;
                last_tag  = exp_q[0].tag;
                void'(exp_q.pop_front());
                model_xfer = model_xfer + 16'd1;
            end
            if (do_push) begin
                e.data = model(in_mode, in_data, in_key);
                e.tag  = in_tag;
                exp_q.push_back(e);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [IW-1:0] rand_data();
        logic [IW-1:0] r;
        for (int i = 0; i < NUM_CH; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [KW-1:0] rand_key();
        logic [KW-1:0] r;
        for (int i = 0; i < NUM_CH; i++) r[i*48 +: 48] = {16'($urandom), 32'($urandom)};
        return r;
    endfunction

    // Entered and left at posedge+1; returns once the offer has been accepted.
    task automatic send(input logic [1:0] m, input logic [IW-1:0] d, input logic [KW-1:0] k,
                        input logic [TAG_W-1:0] t);
        in_valid = 1'b1;
        in_mode  = m;
        in_data  = d;
        in_key   = k;
        in_tag   = t;
        for (int w = 0; w < 40; w++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                in_data  = rand_data();
                in_key   = rand_key();
                return;
            end
            stall_cycles++;
            @(posedge clk);
            #1;
        end
        n_checks++;
        n_errors++;
        $display("FAIL send_timeout: tag %0d never accepted", t);
        in_valid = 1'b0;
    endtask

    task automatic peek(input string name, input logic [OW-1:0] exp, input logic [OW-1:0] mask);
        @(negedge clk);
        check(name, out_data & mask, exp & mask);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    localparam logic [OW-1:0] LANE0 = {{(OW-48){1'b0}}, 48'hFFFF_FFFF_FFFF};
    localparam logic [OW-1:0] ALL   = '1;

    // ---------------- test sequence ----------------
    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", {255'h0, in_ready}, {255'h0, 1'b1});
        @(posedge clk);
        #1;

        // Directed mode examples on lane 0, other lanes random
        out_ready = 1'b1;
        send(2'b00, {rand_data() >> 32, 32'h0000_0001}, rand_key(), 4'd1);
        peek("e_lsb", {{(OW-48){1'b0}}, 48'h8000_0000_0002}, LANE0);
        send(2'b00, {rand_data() >> 32, 32'h8000_0000}, rand_key(), 4'd2);
        peek("e_msb", {{(OW-48){1'b0}}, 48'h4000_0000_0001}, LANE0);
        send(2'b01, {rand_data() >> 32, 32'hFFFF_FFFF}, {rand_key() >> 48, 48'h0F0F_0F0F_0F0F}, 4'd3);
        peek("e_xor_k", {{(OW-48){1'b0}}, 48'hF0F0_F0F0_F0F0}, LANE0);
        send(2'b10, {rand_data() >> 32, 32'h8000_0000}, rand_key(), 4'd4);
        peek("p_msb", {{(OW-48){1'b0}}, 48'h0000_0080_0000}, LANE0);
        send(2'b11, {rand_data() >> 32, 32'h1234_5678}, rand_key(), 4'd5);
        peek("bypass", {{(OW-48){1'b0}}, 48'h0000_1234_5678}, LANE0);

        // Four lanes at once
        send(2'b00, {32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0001}, rand_key(), 4'd6);
        peek("four_lane_e", {48'h0, 48'hFFFF_FFFF_FFFF, 48'h4000_0000_0001, 48'h8000_0000_0002}, ALL);

        // Backpressure: two fill the buffer, the third waits for a drain
        idle(2);
        out_ready = 1'b0;
        send(2'($urandom), rand_data(), rand_key(), 4'd1);
        send(2'($urandom), rand_data(), rand_key(), 4'd2);
        in_valid = 1'b1;
        in_tag   = 4'd3;
        @(negedge clk);
        check("full_blocks_third", {255'h0, in_ready}, 256'h0);
        check("stalled_head_tag", {252'h0, out_tag}, 256'h1);
        idle(3);
        out_ready = 1'b1;
        send(2'($urandom), rand_data(), rand_key(), 4'd3);
        idle(3);

        // Random traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            in_valid  = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            in_mode   = 2'($urandom);
            in_data   = rand_data();
            in_key    = rand_key();
            in_tag    = 4'($urandom);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        idle(3);

        // Streaming: 100 back-to-back with no stalls
        do_reset(1);
        stall_cycles = 0;
        for (int i = 0; i < 100; i++) send(2'($urandom), rand_data(), rand_key(), 4'(i));
        check("stream_no_stall", 256'(stall_cycles), 256'h0);
        idle(3);
        @(negedge clk);
        check("stream_xfer_100", {240'h0, xfer_cnt}, 256'd100);
        @(posedge clk);
        #1;

        // Reset while full with xfer_cnt=5
        do_reset(1);
        for (int i = 0; i < 5; i++) send(2'($urandom), rand_data(), rand_key(), 4'(i));
        idle(3);
        out_ready = 1'b0;
        send(2'b11, rand_data(), rand_key(), 4'd7);
        send(2'b11, rand_data(), rand_key(), 4'd8);
        @(negedge clk);
        check("pre_reset_xfer_5", {240'h0, xfer_cnt}, 256'd5);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("reset_cycle_ready", {255'h0, in_ready}, 256'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_valid", {255'h0, out_valid}, 256'h0);
        check("post_reset_xfer", {240'h0, xfer_cnt}, 256'h0);
        check("post_reset_ready", {255'h0, in_ready}, {255'h0, 1'b1});
        check("post_reset_data", out_data, 256'h0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(2'b00, rand_data(), rand_key(), 4'd9);
        idle(3);
        @(negedge clk);
        check("post_reset_single", {240'h0, xfer_cnt}, 256'd1);
        @(posedge clk);
        #1;

        // Counter wrap after 65535 transfers
        do_reset(1);
        in_valid = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            in_mode = 2'($urandom);
            in_data = rand_data();
            in_key  = rand_key();
            in_tag  = 4'($urandom);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        idle(3);
        @(negedge clk);
        check("xfer_ffff", {240'h0, xfer_cnt}, 256'hFFFF);
        @(posedge clk);
        #1;
        send(2'b10, rand_data(), rand_key(), 4'd10);
        idle(3);
        @(negedge clk);
        check("xfer_wrap", {240'h0, xfer_cnt}, 256'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #3_000_000;
        n_checks++;
        n_errors++;
        $display("FAIL watchdog: sequence did not complete in time");
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
